eth_tx_axis_arbiter: RTL and testbench
======================================

// Module: eth_tx_axis_arbiter
// PURPOSE
// - Frame-level round-robin arbiter sharing the 10G MAC TX AXI-Stream slave (s_axis_t*) between two requesters.
// - Sits in the xgmii_clk domain, between the user/test generators and TEN_GIG_MAC_module.
// - Grants a port only while the PCS link is up.
// - Holds the grant for a whole frame, then inserts a programmable idle gap before the next grant.
// PARAMETERS
// - P_DATA_W     64   tdata width; tkeep width = P_DATA_W/8
// - P_USER_W     80   tuser width (MAC frame metadata, passed through untouched)
// - P_IFG_CYCLES 2    idle cycles forced after each frame's tlast beat; 0 = no gap
// - P_CNT_W      16   width of per-port frame counters
// PORTS
// - i_clk             in   1          xgmii clock
// - i_rst_n           in   1          synchronous reset, active low
// - i_link_up         in   1          block_sync && pcs_rx_link; gates new grants only
// - s0_axis_tdata     in   P_DATA_W   port 0 (higher priority after reset)
// - s0_axis_tuser     in   P_USER_W
// - s0_axis_tkeep     in   P_DATA_W/8
// - s0_axis_tlast     in   1
// - s0_axis_tvalid    in   1
// - s0_axis_tready    out  1
// - s1_axis_*         same as s0, port 1
// - m_axis_tdata/tuser/tkeep/tlast/tvalid  out  as above   to MAC s_axis_t*
// - m_axis_tready     in   1
// - o_grant           out  2          one-hot current owner; 00 when none
// - o_frame_cnt0      out  P_CNT_W    frames completed on port 0, wraps
// - o_frame_cnt1      out  P_CNT_W    frames completed on port 1, wraps
// BEHAVIOUR
// - Reset values (i_rst_n==0 at posedge)
//   - state=IDLE, o_grant=00, all s*_tready=0, m_axis_tvalid=0, counters=0.
//   - RR pointer set so port 0 wins the first tie.
// - FSM: IDLE -> BUSY -> (GAP) -> IDLE.
// - IDLE
//   - If i_link_up and any s*_tvalid: pick a port, register o_grant, go to BUSY.
//   - Pick rule: if only one port is valid, that port; if both are valid, the port not granted last.
//   - No beat is transferred in the IDLE cycle, so there is 1 bubble per frame.
// - BUSY
//   - Combinational mux, 0-cycle latency: m_axis_* = granted s*_axis_*.
//   - Granted s_tready = m_axis_tready. Non-granted s_tready = 0.
//   - Handshake: a beat moves when m_axis_tvalid && m_axis_tready.
//   - On a beat with tlast: increment that port's counter, update the RR pointer, clear o_grant.
//     - Go to GAP if P_IFG_CYCLES>0 (gap counter loaded with P_IFG_CYCLES-1).
//     - Otherwise go to IDLE.
//   - i_link_up falling mid-frame does not abort: the frame completes.
//   - Source tvalid gaps mid-frame: the grant is held indefinitely, with no timeout.
// - GAP
//   - m_axis_tvalid=0, all s*_tready=0; count down to 0, then go to IDLE.
// - Outside BUSY: m_axis_tvalid=0; m_axis_tdata/tuser/tkeep/tlast are driven 0.
// - Counters wrap modulo 2^P_CNT_W. No saturation.
// - A single-beat frame (tvalid and tlast together) is legal: BUSY lasts 1 cycle when tready=1.
// - Reset mid-frame: immediate return to reset values. The partial frame is truncated and is the source's responsibility.
// STRUCTURE
// - Shared package eth_tx_pkg:
//   - state encoding localparams ST_IDLE/ST_BUSY/ST_GAP
//   - AXIS width constants (64/80/8)
// - One sub-module, eth_rr_pick2:
//   - combinational 2-requester round-robin chooser
//   - inputs: req[1:0], last_grant
//   - output: one-hot gnt[1:0]
// - The mux, FSM, gap counter and frame counters stay in this module.
// TESTING
// - T1 reset/idle
//   - Stimulus: hold i_rst_n=0 for 5 cycles with both valids high.
//   - Required: o_grant=00, s0/s1_tready=0, m_tvalid=0, counters=0.
// - T2 single port
//   - Stimulus: link up; s0 sends 4-beat frame, tkeep last=8'h0F, tready=1.
//   - Required: 1 IDLE bubble, 4 beats on m with identical data/tuser/tkeep; o_frame_cnt0=1; then 2 GAP cycles with tvalid=0.
// - T3 round robin
//   - Stimulus: both ports continuously valid, 3-beat frames.
//   - Required: grant order 0,1,0,1 and cnt0=cnt1=2 after 4 frames.
// - T4 backpressure
//   - Stimulus: m_tready toggles 1,0,1,0 during a 5-beat s1 frame.
//   - Required: s1_tready mirrors m_tready; no beat lost or duplicated; s0_tready stays 0.
// - T5 link gating
//   - Stimulus: i_link_up=0 with s0 valid.
//   - Required: no grant.
//   - Stimulus: raise the link, drop it after beat 2 of 6.
//   - Required: the frame completes all 6 beats, then no new grant while the link is down.
// - T6 wrap and reset mid-frame
//   - Stimulus: with P_CNT_W=4, send 17 frames on s0.
//   - Required: o_frame_cnt0 = 1.
//   - Stimulus: assert i_rst_n=0 at beat 2.
//   - Required: next cycle state IDLE, tready=0, counters=0.

Source files
------------

// File: rtl/eth_tx_pkg.sv
// Shared types and widths for the 10G MAC TX stream arbiter.
// Imported by the arbiter top and its round-robin chooser.
package eth_tx_pkg;

  localparam int AXIS_DATA_W = 64;
  localparam int AXIS_USER_W = 80;
  localparam int AXIS_KEEP_W = AXIS_DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/eth_rr_pick2.sv
// Two-requester round-robin chooser, purely combinational.
// last_grant_i=1 means port 1 owned the previous frame.
module eth_rr_pick2
  import eth_tx_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_grant_i ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/eth_tx_axis_arbiter.sv
// Frame-level round-robin arbiter feeding the 10G MAC TX stream,
// with link gating and a programmable inter-frame idle gap.
module eth_tx_axis_arbiter
  import eth_tx_pkg::*;
#(
  parameter int P_DATA_W     = AXIS_DATA_W,
  parameter int P_USER_W     = AXIS_USER_W,
  parameter int P_IFG_CYCLES = 2,
  parameter int P_CNT_W      = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_link_up,
  input  logic [P_DATA_W-1:0]   s0_axis_tdata,
  input  logic [P_USER_W-1:0]   s0_axis_tuser,
  input  logic [P_DATA_W/8-1:0] s0_axis_tkeep,
  input  logic                  s0_axis_tlast,
  input  logic                  s0_axis_tvalid,
  output logic                  s0_axis_tready,
  input  logic [P_DATA_W-1:0]   s1_axis_tdata,
  input  logic [P_USER_W-1:0]   s1_axis_tuser,
  input  logic [P_DATA_W/8-1:0] s1_axis_tkeep,
  input  logic                  s1_axis_tlast,
  input  logic                  s1_axis_tvalid,
  output logic                  s1_axis_tready,
  output logic [P_DATA_W-1:0]   m_axis_tdata,
  output logic [P_USER_W-1:0]   m_axis_tuser,
  output logic [P_DATA_W/8-1:0] m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [1:0]            o_grant,
  output logic [P_CNT_W-1:0]    o_frame_cnt0,
  output logic [P_CNT_W-1:0]    o_frame_cnt1
);

  localparam int GAP_W =
    (P_IFG_CYCLES > 1) ? $clog2(P_IFG_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD =
    (P_IFG_CYCLES > 0) ? GAP_W'(P_IFG_CYCLES - 1) : '0;

  state_t             state_q;
  logic [1:0]         grant_q;
  logic               last_q;
  logic [GAP_W-1:0]   gap_q;
  logic [P_CNT_W-1:0] cnt0_q;
  logic [P_CNT_W-1:0] cnt1_q;
  logic [P_CNT_W-1:0] cnt0_d;
  logic [P_CNT_W-1:0] cnt1_d;

  logic       busy;
  logic       sel1;
  logic       beat_last;
  logic [1:0] pick;

  assign busy = (state_q == ST_BUSY);
  assign sel1 = grant_q[1];

  eth_rr_pick2 u_pick (
    .req_i        ({s1_axis_tvalid, s0_axis_tvalid}),
    .last_grant_i (last_q),
    .gnt_o        (pick)
  );

  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tuser  = '0;
    m_axis_tkeep  = '0;
    m_axis_tlast  = 1'b0;
    if (busy) begin
      if (sel1) begin
        m_axis_tvalid = s1_axis_tvalid;
        m_axis_tdata  = s1_axis_tdata;
        m_axis_tuser  = s1_axis_tuser;
        m_axis_tkeep  = s1_axis_tkeep;
        m_axis_tlast  = s1_axis_tlast;
      end else begin
        m_axis_tvalid = s0_axis_tvalid;
        m_axis_tdata  = s0_axis_tdata;
        m_axis_tuser  = s0_axis_tuser;
        m_axis_tkeep  = s0_axis_tkeep;
        m_axis_tlast  = s0_axis_tlast;
      end
    end
  end

  assign s0_axis_tready = busy & grant_q[0] & m_axis_tready;
  assign s1_axis_tready = busy & grant_q[1] & m_axis_tready;

  assign beat_last =
    m_axis_tvalid & m_axis_tready & m_axis_tlast;

  assign cnt0_d = cnt0_q + P_CNT_W'(1);
  assign cnt1_d = cnt1_q + P_CNT_W'(1);

  // last_q resets to 1 so port 0 wins the first tie
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
      gap_q   <= '0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (i_link_up && pick != 2'b00) begin
            grant_q <= pick;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (beat_last) begin
            grant_q <= 2'b00;
            last_q  <= sel1;
            if (sel1) cnt1_q <= cnt1_d;
            else      cnt0_q <= cnt0_d;
            if (P_IFG_CYCLES > 0) begin
              state_q <= ST_GAP;
              gap_q   <= GAP_LOAD;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_GAP: begin
          if (gap_q == '0) state_q <= ST_IDLE;
          else             gap_q   <= gap_q - GAP_W'(1);
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_grant      = grant_q;
  assign o_frame_cnt0 = cnt0_q;
  assign o_frame_cnt1 = cnt1_q;

endmodule

// File: tb/tb_eth_tx_axis_arbiter.sv
// Randomized bench for eth_tx_axis_arbiter: per-port frame queues
// are the reference, and the observed MAC-side stream is checked.
module tb_eth_tx_axis_arbiter;

  localparam int DW  = 64;
  localparam int UW  = 80;
  localparam int KW  = DW / 8;
  localparam int IFG = 2;
  localparam int CW  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          link;
  logic [DW-1:0] s0_tdata, s1_tdata, m_tdata;
  logic [UW-1:0] s0_tuser, s1_tuser, m_tuser;
  logic [KW-1:0] s0_tkeep, s1_tkeep, m_tkeep;
  logic          s0_tlast, s1_tlast, m_tlast;
  logic          s0_tvalid, s1_tvalid, m_tvalid;
  logic          s0_tready, s1_tready, m_tready;
  logic [1:0]    grant;
  logic [CW-1:0] cnt0, cnt1;

  eth_tx_axis_arbiter #(
    .P_DATA_W     (DW),
    .P_USER_W     (UW),
    .P_IFG_CYCLES (IFG),
    .P_CNT_W      (CW)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_link_up      (link),
    .s0_axis_tdata  (s0_tdata),
    .s0_axis_tuser  (s0_tuser),
    .s0_axis_tkeep  (s0_tkeep),
    .s0_axis_tlast  (s0_tlast),
    .s0_axis_tvalid (s0_tvalid),
    .s0_axis_tready (s0_tready),
    .s1_axis_tdata  (s1_tdata),
    .s1_axis_tuser  (s1_tuser),
    .s1_axis_tkeep  (s1_tkeep),
    .s1_axis_tlast  (s1_tlast),
    .s1_axis_tvalid (s1_tvalid),
    .s1_axis_tready (s1_tready),
    .m_axis_tdata   (m_tdata),
    .m_axis_tuser   (m_tuser),
    .m_axis_tkeep   (m_tkeep),
    .m_axis_tlast   (m_tlast),
    .m_axis_tvalid  (m_tvalid),
    .m_axis_tready  (m_tready),
    .o_grant        (grant),
    .o_frame_cnt0   (cnt0),
    .o_frame_cnt1   (cnt1)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [UW-1:0] u;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  beat_t      src0[$], src1[$], exp0[$], exp1[$], obs[$];
  int         obs_port[$], obs_cyc[$];
  logic [1:0] g_trace[$];
  logic       mv_trace[$];
  int n_mirror_bad, n_nz_idle, n_s0rdy, leftover;
  int total = 0;
  int bad   = 0;

  function automatic beat_t rand_beat(input bit last,
                                      input logic [KW-1:0] kl);
    beat_t b;
    b.d = {$urandom, $urandom};
    b.u = UW'({$urandom, $urandom, $urandom});
    b.k = last ? kl : '1;
    b.l = last;
    return b;
  endfunction

  task automatic gen_frame(input int port, input int len,
                           input logic [KW-1:0] kl);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b = rand_beat(i == len - 1, kl);
      if (port == 0) begin
        src0.push_back(b);
        exp0.push_back(b);
      end else begin
        src1.push_back(b);
        exp1.push_back(b);
      end
    end
  endtask

  // observed beats must be an in-order prefix of each port's queue
  function automatic int seq_errs();
    int i0 = 0;
    int i1 = 0;
    int e  = 0;
    foreach (obs[i]) begin
      if (obs_port[i] == 0) begin
        if (i0 >= exp0.size() || obs[i] !== exp0[i0]) e++;
        i0++;
      end else begin
        if (i1 >= exp1.size() || obs[i] !== exp1[i1]) e++;
        i1++;
      end
    end
    return e;
  endfunction

  // frames may not interleave; tlast to next beat is >= IFG+2
  function automatic int frame_errs();
    int e = 0;
    for (int i = 1; i < obs.size(); i++) begin
      if (!obs[i-1].l && obs_port[i] != obs_port[i-1]) e++;
      if (obs[i-1].l && obs_cyc[i] - obs_cyc[i-1] < IFG + 2) e++;
    end
    return e;
  endfunction

  task automatic do_reset();
    rst_n     = 1'b0;
    link      = 1'b0;
    s0_tvalid = 1'b0;
    s1_tvalid = 1'b0;
    m_tready  = 1'b0;
    src0.delete(); src1.delete();
    exp0.delete(); exp1.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // rpct<0: tready toggles, high on odd cycles
  // drop_after>=0: link falls once that many beats have moved
  task automatic run_traffic(input int max_cyc, input int vpct,
                             input int rpct, input int drop_after);
    bit hs0 = 1'b0;
    bit hs1 = 1'b0;
    int nbeats = 0;
    int tail = 0;
    beat_t b;
    obs.delete(); obs_port.delete(); obs_cyc.delete();
    g_trace.delete(); mv_trace.delete();
    n_mirror_bad = 0; n_nz_idle = 0; n_s0rdy = 0;
    for (int k = 0; k < max_cyc; k++) begin
      if (hs0) b = src0.pop_front();
      if (hs1) b = src1.pop_front();
      if (src0.size() == 0 && src1.size() == 0) tail++;
      if (tail > 8) break;
      if (!(s0_tvalid && !hs0)) begin
        if (src0.size() > 0 && $urandom_range(99) < vpct) begin
          {s0_tdata, s0_tuser, s0_tkeep, s0_tlast} = src0[0];
          s0_tvalid = 1'b1;
        end else begin
          b = rand_beat(1'b1, '1);
          {s0_tdata, s0_tuser, s0_tkeep, s0_tlast} = b;
          s0_tvalid = 1'b0;
        end
      end
      if (!(s1_tvalid && !hs1)) begin
        if (src1.size() > 0 && $urandom_range(99) < vpct) begin
          {s1_tdata, s1_tuser, s1_tkeep, s1_tlast} = src1[0];
          s1_tvalid = 1'b1;
        end else begin
          b = rand_beat(1'b1, '1);
          {s1_tdata, s1_tuser, s1_tkeep, s1_tlast} = b;
          s1_tvalid = 1'b0;
        end
      end
      if (rpct < 0) m_tready = (k % 2 == 1);
      else          m_tready = ($urandom_range(99) < rpct);
      link = !(drop_after >= 0 && nbeats >= drop_after);
      @(negedge clk);
      g_trace.push_back(grant);
      mv_trace.push_back(m_tvalid);
      if (s0_tready !== (grant[0] & m_tready) ||
          s1_tready !== (grant[1] & m_tready))
        n_mirror_bad++;
      if (grant == 2'b00 &&
          (m_tvalid !== 1'b0 || m_tdata !== '0 ||
           m_tuser !== '0 || m_tkeep !== '0 || m_tlast !== 1'b0))
        n_nz_idle++;
      if (s0_tready === 1'b1) n_s0rdy++;
      hs0 = s0_tvalid && s0_tready;
      hs1 = s1_tvalid && s1_tready;
      if (m_tvalid && m_tready) begin
        obs.push_back({m_tdata, m_tuser, m_tkeep, m_tlast});
        obs_port.push_back(grant[1] ? 1 : 0);
        obs_cyc.push_back(k);
        nbeats++;
      end
      @(posedge clk);
      #1;
    end
    leftover = src0.size() + src1.size();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    link      = 1'b1;
    m_tready  = 1'b1;
    s0_tvalid = 1'b1;
    s1_tvalid = 1'b1;
    {s0_tdata, s0_tuser, s0_tkeep, s0_tlast} = rand_beat(1'b1, '1);
    {s1_tdata, s1_tuser, s1_tkeep, s1_tlast} = rand_beat(1'b0, '1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    total++;
    if (grant !== 2'b00) begin
      bad++; $display("FAIL rst_grant: got %b want 00", grant);
    end
    total++;
    if (s0_tready !== 1'b0 || s1_tready !== 1'b0) begin
      bad++;
      $display("FAIL rst_tready: got %b%b want 00",
               s1_tready, s0_tready);
    end
    total++;
    if (m_tvalid !== 1'b0) begin
      bad++; $display("FAIL rst_mvalid: got %b want 0", m_tvalid);
    end
    total++;
    if (cnt0 !== '0 || cnt1 !== '0) begin
      bad++;
      $display("FAIL rst_cnt: got %0d/%0d want 0/0", cnt0, cnt1);
    end
    total++;
    if (m_tdata !== '0) begin
      bad++; $display("FAIL rst_mdata: got %h want 0", m_tdata);
    end
  endtask

  task automatic test_single_port();
    do_reset();
    gen_frame(0, 4, 8'h0F);
    run_traffic(60, 100, 100, -1);
    total++;
    if (obs.size() != 4) begin
      bad++;
      $display("FAIL single_nbeats: got %0d want 4", obs.size());
    end else begin
      total++;
      if (seq_errs() != 0) begin
        bad++;
        $display("FAIL single_data: got %0d errs want 0", seq_errs());
      end
      total++;
      if (obs_cyc[0] != 1 || obs_cyc[3] != 4) begin
        bad++;
        $display("FAIL single_timing: got %0d..%0d want 1..4",
                 obs_cyc[0], obs_cyc[3]);
      end
      total++;
      if (obs[3].k !== 8'h0F) begin
        bad++; $display("FAIL single_keep: got %h want 0f", obs[3].k);
      end
    end
    total++;
    if (g_trace[0] !== 2'b00 || g_trace[1] !== 2'b01) begin
      bad++;
      $display("FAIL single_grant: got %b,%b want 00,01",
               g_trace[0], g_trace[1]);
    end
    total++;
    if (g_trace[5] !== 2'b00 || g_trace[6] !== 2'b00 ||
        mv_trace[5] !== 1'b0 || mv_trace[6] !== 1'b0) begin
      bad++;
      $display("FAIL single_gap: got g=%b,%b v=%b,%b want 0",
               g_trace[5], g_trace[6], mv_trace[5], mv_trace[6]);
    end
    total++;
    if (cnt0 !== CW'(1) || cnt1 !== '0) begin
      bad++;
      $display("FAIL single_cnt: got %0d/%0d want 1/0", cnt0, cnt1);
    end
    total++;
    if (n_nz_idle != 0) begin
      bad++;
      $display("FAIL single_idle_zero: got %0d want 0", n_nz_idle);
    end
  endtask

  task automatic test_round_robin();
    int r0 = 2;
    int r1 = 2;
    int last = 1;
    int p;
    int order[$];
    int st_port[$];
    int st_cyc[$];
    do_reset();
    for (int f = 0; f < 2; f++) begin
      gen_frame(0, 3, '1);
      gen_frame(1, 3, '1);
    end
    while (r0 > 0 || r1 > 0) begin
      if (r0 > 0 && r1 > 0) p = (last == 1) ? 0 : 1;
      else                  p = (r0 > 0) ? 0 : 1;
      order.push_back(p);
      last = p;
      if (p == 0) r0--; else r1--;
    end
    run_traffic(200, 100, 100, -1);
    foreach (obs[i]) begin
      if (i == 0 || obs[i-1].l) begin
        st_port.push_back(obs_port[i]);
        st_cyc.push_back(obs_cyc[i]);
      end
    end
    total++;
    if (st_port.size() != order.size()) begin
      bad++;
      $display("FAIL rr_frames: got %0d want %0d",
               st_port.size(), order.size());
    end else begin
      foreach (order[f]) begin
        total++;
        if (st_port[f] != order[f]) begin
          bad++;
          $display("FAIL rr_order[%0d]: got %0d want %0d",
                   f, st_port[f], order[f]);
        end
        total++;
        if (st_cyc[f] != 1 + f * (3 + IFG + 1)) begin
          bad++;
          $display("FAIL rr_start[%0d]: got %0d want %0d",
                   f, st_cyc[f], 1 + f * (3 + IFG + 1));
        end
      end
    end
    total++;
    if (seq_errs() != 0 || frame_errs() != 0) begin
      bad++;
      $display("FAIL rr_data: got %0d/%0d errs want 0",
               seq_errs(), frame_errs());
    end
    total++;
    if (cnt0 !== CW'(2) || cnt1 !== CW'(2)) begin
      bad++;
      $display("FAIL rr_cnt: got %0d/%0d want 2/2", cnt0, cnt1);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    gen_frame(1, 5, 8'h3F);
    run_traffic(100, 100, -1, -1);
    total++;
    if (obs.size() != 5 || seq_errs() != 0) begin
      bad++;
      $display("FAIL bp_beats: got %0d beats %0d errs want 5/0",
               obs.size(), seq_errs());
    end else begin
      total++;
      if (obs_cyc[4] != 9) begin
        bad++;
        $display("FAIL bp_last_cyc: got %0d want 9", obs_cyc[4]);
      end
    end
    total++;
    if (n_mirror_bad != 0) begin
      bad++;
      $display("FAIL bp_mirror: got %0d want 0", n_mirror_bad);
    end
    total++;
    if (n_s0rdy != 0) begin
      bad++; $display("FAIL bp_s0_rdy: got %0d want 0", n_s0rdy);
    end
    total++;
    if (cnt1 !== CW'(1) || cnt0 !== '0) begin
      bad++;
      $display("FAIL bp_cnt: got %0d/%0d want 0/1", cnt0, cnt1);
    end
  endtask

  task automatic test_link();
    int ng = 0;
    do_reset();
    gen_frame(0, 6, '1);
    run_traffic(20, 100, 100, 0);
    foreach (g_trace[i]) if (g_trace[i] !== 2'b00) ng++;
    total++;
    if (ng != 0 || obs.size() != 0 || n_s0rdy != 0) begin
      bad++;
      $display("FAIL link_down: got g=%0d b=%0d r=%0d want 0",
               ng, obs.size(), n_s0rdy);
    end
    total++;
    if (leftover != 6) begin
      bad++; $display("FAIL link_hold: got %0d want 6", leftover);
    end
    gen_frame(0, 3, '1);
    run_traffic(60, 100, 100, 2);
    total++;
    if (obs.size() != 6 || seq_errs() != 0) begin
      bad++;
      $display("FAIL link_complete: got %0d beats %0d errs want 6/0",
               obs.size(), seq_errs());
    end else begin
      ng = 0;
      foreach (g_trace[i])
        if (i > obs_cyc[5] && g_trace[i] !== 2'b00) ng++;
      total++;
      if (ng != 0) begin
        bad++; $display("FAIL link_no_regrant: got %0d want 0", ng);
      end
    end
    total++;
    if (leftover != 3 || cnt0 !== CW'(1)) begin
      bad++;
      $display("FAIL link_after: got left=%0d cnt=%0d want 3/1",
               leftover, cnt0);
    end
  endtask

  task automatic test_wrap_reset();
    beat_t b;
    do_reset();
    for (int f = 0; f < 17; f++)
      gen_frame(0, $urandom_range(1, 3), KW'($urandom_range(1, 255)));
    run_traffic(2000, 80, 80, -1);
    total++;
    if (leftover != 0 || seq_errs() != 0 || frame_errs() != 0) begin
      bad++;
      $display("FAIL wrap_data: got left=%0d errs=%0d/%0d want 0",
               leftover, seq_errs(), frame_errs());
    end
    total++;
    if (cnt0 !== CW'(1) || cnt1 !== '0) begin
      bad++;
      $display("FAIL wrap_cnt: got %0d/%0d want 1/0", cnt0, cnt1);
    end
    b = rand_beat(1'b0, '1);
    {s0_tdata, s0_tuser, s0_tkeep, s0_tlast} = b;
    s0_tvalid = 1'b1;
    m_tready  = 1'b1;
    link      = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (m_tvalid !== 1'b1 || grant !== 2'b01) begin
      bad++;
      $display("FAIL midrst_inflight: got v=%b g=%b want 1/01",
               m_tvalid, grant);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (grant !== 2'b00 || s0_tready !== 1'b0 ||
        m_tvalid !== 1'b0) begin
      bad++;
      $display("FAIL midrst_state: got g=%b r=%b v=%b want 0",
               grant, s0_tready, m_tvalid);
    end
    total++;
    if (cnt0 !== '0 || cnt1 !== '0) begin
      bad++;
      $display("FAIL midrst_cnt: got %0d/%0d want 0/0", cnt0, cnt1);
    end
    @(posedge clk); #1;
    s0_tvalid = 1'b0;
  endtask

  task automatic test_random();
    int n0, n1;
    for (int it = 0; it < 3; it++) begin
      do_reset();
      n0 = $urandom_range(1, 6);
      n1 = $urandom_range(1, 6);
      for (int f = 0; f < 6; f++) begin
        if (f < n0) gen_frame(0, $urandom_range(1, 5),
                              KW'($urandom_range(1, 255)));
        if (f < n1) gen_frame(1, $urandom_range(1, 5),
                              KW'($urandom_range(1, 255)));
      end
      run_traffic(3000, $urandom_range(60, 100),
                  $urandom_range(50, 100), -1);
      total++;
      if (leftover != 0) begin
        bad++;
        $display("FAIL rand%0d_timeout: got %0d left want 0",
                 it, leftover);
      end
      total++;
      if (seq_errs() != 0 || frame_errs() != 0) begin
        bad++;
        $display("FAIL rand%0d_stream: got %0d/%0d errs want 0",
                 it, seq_errs(), frame_errs());
      end
      total++;
      if (cnt0 !== CW'(n0) || cnt1 !== CW'(n1)) begin
        bad++;
        $display("FAIL rand%0d_cnt: got %0d/%0d want %0d/%0d",
                 it, cnt0, cnt1, n0, n1);
      end
      total++;
      if (n_mirror_bad != 0 || n_nz_idle != 0) begin
        bad++;
        $display("FAIL rand%0d_ctrl: got %0d/%0d want 0/0",
                 it, n_mirror_bad, n_nz_idle);
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    link      = 1'b0;
    s0_tvalid = 1'b0;
    s1_tvalid = 1'b0;
    m_tready  = 1'b0;
    test_reset();
    test_single_port();
    test_round_robin();
    test_backpressure();
    test_link();
    test_wrap_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
